// File: rtl/fetch_decode.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the 8-bit, 4-register datapath.
// Optional single-step gating when SINGLE_STEP_EN is defined.
module fetch_decode #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            run,
`ifdef SINGLE_STEP_EN
   input  logic            step,
`endif
   output logic [PC_W-1:0] imem_addr,
   input  logic [7:0]      imem_data,
   output logic [1:0]      read_register1,
   output logic [1:0]      read_register2,
   output logic [1:0]      destination_register,
   output logic            regdst,
   output logic            regwrite,
   output logic            alusrc,
   output logic            memread,
   output logic            memwrite,
   output logic            memtoreg,
   output logic [7:0]      imm_ext,
   output logic [PC_W-1:0] pc,
   output logic [1:0]      state
);

   typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_WB} state_t;
   typedef enum logic [1:0] {OP_ADD, OP_LOAD, OP_STORE, OP_JUMP} op_t;

   state_t          st, st_nxt;
   logic [7:0]      ir;
   op_t             op;
   logic            go;
   logic [PC_W-1:0] jmp_off;

   assign op      = op_t'(ir[7:6]);
   // PC_W is assumed to be at least 6 so the jump offset fits.
   assign jmp_off = {{(PC_W-6){ir[5]}}, ir[5:0]};

`ifdef SINGLE_STEP_EN
   logic step_q;
   always_ff @(posedge CLK) begin
      if (RESET) step_q <= 1'b0;
      else       step_q <= step;
   end
   assign go = run & step & ~step_q;
`else
   assign go = run;
`endif

   always_ff @(posedge CLK) begin
      if (RESET) begin
         st <= S_FETCH;
         pc <= RESET_PC;
         ir <= '0;
      end else begin
         st <= st_nxt;
         if (st == S_DECODE) begin
            ir <= imem_data;
            pc <= pc + PC_W'(1);
         end else if (st == S_EXEC && op == OP_JUMP) begin
            pc <= pc + jmp_off;
         end
      end
   end

   always_comb begin
      st_nxt   = st;
      regdst   = 1'b0;
      alusrc   = 1'b0;
      memtoreg = 1'b0;
      regwrite = 1'b0;
      memread  = 1'b0;
      memwrite = 1'b0;
      case (st)
         S_FETCH:  if (go) st_nxt = S_DECODE;
         S_DECODE: st_nxt = S_EXEC;
         S_EXEC:   st_nxt = (op == OP_JUMP) ? S_FETCH : S_WB;
         S_WB:     st_nxt = S_FETCH;
         default:  st_nxt = S_FETCH;
      endcase
      // Static controls hold from EXEC through WB; strobes fire only in WB.
      if (st == S_EXEC || st == S_WB) begin
         regdst   = (op == OP_ADD);
         alusrc   = (op == OP_LOAD) || (op == OP_STORE);
         memtoreg = (op == OP_LOAD);
      end
      if (st == S_WB) begin
         regwrite = (op == OP_ADD) || (op == OP_LOAD);
         memread  = (op == OP_LOAD);
         memwrite = (op == OP_STORE);
      end
   end

   assign imem_addr            = pc;
   assign read_register1       = ir[5:4];
   assign read_register2       = ir[3:2];
   assign destination_register = ir[1:0];
   assign imm_ext              = {{6{ir[1]}}, ir[1:0]};
   assign state                = st;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode; covers the single-step gate when SINGLE_STEP_EN is defined.
module tb_fetch_decode;

   logic       CLK;
   logic       RESET;
   logic       run;
   logic [7:0] imem_addr;
   logic [7:0] imem_data;
   logic [1:0] read_register1, read_register2, destination_register;
   logic       regdst, regwrite, alusrc, memread, memwrite, memtoreg;
   logic [7:0] imm_ext;
   logic [7:0] pc;
   logic [1:0] state;
`ifdef SINGLE_STEP_EN
   logic       step;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   int n_wb;

   logic [7:0] imem [256];

   fetch_decode #(.PC_W(8), .RESET_PC(8'h00)) dut (
      .CLK(CLK), .RESET(RESET), .run(run),
`ifdef SINGLE_STEP_EN
      .step(step),
`endif
      .imem_addr(imem_addr), .imem_data(imem_data),
      .read_register1(read_register1), .read_register2(read_register2),
      .destination_register(destination_register),
      .regdst(regdst), .regwrite(regwrite), .alusrc(alusrc),
      .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
      .imm_ext(imm_ext), .pc(pc), .state(state)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) imem_data <= imem[imem_addr];

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_strobes(input string tag, input logic [2:0] exp);
      chk(tag, {29'd0, regwrite, memread, memwrite}, {29'd0, exp});
   endtask

   initial begin
      for (int i = 0; i < 256; i++) imem[i] = 8'h00;
      imem[0] = 8'b00_01_10_11;  // ADD  r3 = r1 + r2
      imem[1] = 8'b01_00_01_11;  // LOAD r1 = mem[r0 - 1]
      imem[2] = 8'b10_10_00_01;  // STORE mem[r2 + 1] = r0
      imem[3] = 8'b11_000001;    // JUMP +1 -> 5
      imem[5] = 8'b11_111101;    // JUMP -3 -> 3
      RESET = 1'b1;
      run   = 1'b0;
`ifdef SINGLE_STEP_EN
      step  = 1'b0;
`endif
      tick();
      tick();
      chk("rst_state", state, 0);
      chk("rst_pc", pc, 0);
      chk_strobes("rst_strobes", 3'b000);
      chk("rst_ctrl", {regdst, alusrc, memtoreg}, 0);
      chk("rst_ir_fields", {read_register1, read_register2, destination_register}, 0);
      RESET = 1'b0;
      run   = 1'b1;

`ifdef SINGLE_STEP_EN
      tick();
      chk("ss_hold_no_step", state, 0);
      step = 1'b1;
      n_wb = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (state == 2'd3) n_wb++;
      end
      chk("ss_held_one_retire", n_wb, 1);
      chk("ss_held_pc", pc, 1);
      chk("ss_held_state", state, 0);
      step = 1'b0;
      tick();
      step = 1'b1;
      n_wb = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (state == 2'd3) n_wb++;
      end
      chk("ss_second_retire", n_wb, 1);
      chk("ss_second_pc", pc, 2);
      chk("ss_second_state", state, 0);
`else
      // ADD
      tick();
      chk("add_decode_state", state, 1);
      chk("add_decode_pc", pc, 0);
      chk("add_decode_ctrl", {regdst, alusrc, memtoreg}, 0);
      tick();
      chk("add_exec_state", state, 2);
      chk("add_exec_pc", pc, 1);
      chk("add_exec_ctrl", {regdst, alusrc, memtoreg}, 3'b100);
      chk_strobes("add_exec_strobes", 3'b000);
      tick();
      chk("add_wb_state", state, 3);
      chk_strobes("add_wb_strobes", 3'b100);
      chk("add_wb_ctrl", {regdst, alusrc, memtoreg}, 3'b100);
      chk("add_wb_fields", {read_register1, read_register2, destination_register}, 6'b01_10_11);
      tick();
      chk("add_done_state", state, 0);
      chk("add_done_pc", pc, 1);
      chk_strobes("add_done_strobes", 3'b000);
      chk("add_done_ctrl", {regdst, alusrc, memtoreg}, 0);
      // LOAD
      tick();
      tick();
      chk("load_exec_state", state, 2);
      chk("load_exec_ctrl", {regdst, alusrc, memtoreg}, 3'b011);
      chk_strobes("load_exec_strobes", 3'b000);
      tick();
      chk("load_wb_state", state, 3);
      chk_strobes("load_wb_strobes", 3'b110);
      chk("load_wb_ctrl", {regdst, alusrc, memtoreg}, 3'b011);
      chk("load_wb_imm", imm_ext, 8'hFF);
      tick();
      chk("load_done_pc", pc, 2);
      // STORE
      tick();
      tick();
      chk_strobes("store_exec_strobes", 3'b000);
      chk("store_exec_alusrc", alusrc, 1);
      tick();
      chk("store_wb_state", state, 3);
      chk_strobes("store_wb_strobes", 3'b001);
      chk("store_wb_imm", imm_ext, 8'h01);
      chk("store_wb_fields", {read_register1, read_register2, destination_register}, 6'b10_00_01);
      tick();
      chk_strobes("store_done_strobes", 3'b000);
      chk("store_next_addr", imem_addr, 3);
      // JUMP +1 from pc=3
      tick();
      tick();
      chk("jmp1_exec_state", state, 2);
      chk("jmp1_exec_pc", pc, 4);
      chk_strobes("jmp1_exec_strobes", 3'b000);
      tick();
      chk("jmp1_no_wb", state, 0);
      chk("jmp1_pc", pc, 5);
      // JUMP -3 from pc=5
      tick();
      tick();
      chk("jmp2_exec_pc", pc, 6);
      tick();
      chk("jmp2_no_wb", state, 0);
      chk("jmp2_pc", pc, 3);
      chk_strobes("jmp2_strobes", 3'b000);
      // run dropped mid-instruction
      tick();
      chk("hold_decode", state, 1);
      run = 1'b0;
      tick();
      chk("hold_exec", state, 2);
      tick();
      chk("hold_fetch", state, 0);
      chk("hold_pc", pc, 5);
      tick();
      tick();
      chk("hold_stay", state, 0);
      chk("hold_addr", imem_addr, 5);
      // wrap and zero-offset jumps
      imem[5]    = 8'b11_111001; // -7: 6 - 7 -> FF
      imem[8'hFF] = 8'b11_000001; // +1: 00 + 1 -> 01
      imem[1]    = 8'b11_000000; // 0: no-op branch
      imem[2]    = 8'b00_01_10_11;
      run = 1'b1;
      tick();
      tick();
      tick();
      chk("wrapneg_pc", pc, 8'hFF);
      tick();
      tick();
      chk("wrap_inc_pc", pc, 8'h00);
      tick();
      chk("wrap_pc", pc, 8'h01);
      tick();
      tick();
      tick();
      chk("jmp0_pc", pc, 8'h02);
      chk("jmp0_state", state, 0);
      // reset during EXEC of ADD
      tick();
      tick();
      chk("rstx_exec_state", state, 2);
      chk("rstx_exec_regdst", regdst, 1);
      RESET = 1'b1;
      tick();
      chk("rstx_state", state, 0);
      chk("rstx_pc", pc, 0);
      chk_strobes("rstx_strobes", 3'b000);
      RESET = 1'b0;
      run   = 1'b0;
      n_wb  = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (regwrite || state != 2'd0) n_wb++;
      end
      chk("rstx_quiet", n_wb, 0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fetch_decode.md
Name: fetch_decode

Overview:
Multi-cycle instruction fetch and decode sequencer for the 8-bit, 4-register datapath. It owns the PC and fetches from a synchronous instruction memory. It latches the instruction and drives the register-file field selects (rs/rt/rd), regdst, regwrite and the ALU/memory control strobes through a FETCH/DECODE/EXEC/WB state machine. It is the stage directly upstream of the register file.

Parameters:
PC_W, 8, PC and instruction-memory address width
RESET_PC, 0, PC value loaded on reset

Ports:
CLK  input  1  system clock, all state on posedge
RESET  input  1  synchronous, active-high reset
run  input  1  1 = sequencer may leave FETCH; 0 = hold in FETCH
imem_addr  output  PC_W  instruction memory address, equals pc
imem_data  input  8  instruction word, valid the cycle after imem_addr is presented
read_register1  output  2  rs = ir[5:4]
read_register2  output  2  rt = ir[3:2]
destination_register  output  2  rd = ir[1:0]
regdst  output  1  1 = write rd (ADD), 0 = write rt (LOAD)
regwrite  output  1  one-cycle register-file write strobe
alusrc  output  1  1 = ALU B operand is imm_ext
memread  output  1  data-memory read strobe
memwrite  output  1  data-memory write strobe
memtoreg  output  1  1 = write-back data from memory
imm_ext  output  8  sign-extended ir[1:0]
pc  output  PC_W  current program counter
state  output  2  FETCH=0, DECODE=1, EXEC=2, WB=3

Behaviour:
- Instruction format: op = ir[7:6]. 00 ADD rd=rs+rt. 01 LOAD rt=mem[rs+sext(imm)]. 10 STORE mem[rs+sext(imm)]=rt. 11 JUMP pc=pc+sext(ir[5:0]), using the already-incremented pc.
- Reset (sync, RESET high at posedge): state=FETCH, pc=RESET_PC, ir=0. All strobes are 0: regwrite, memread, memwrite. regdst, alusrc and memtoreg are 0. Reset overrides run and any in-progress instruction. An instruction aborted mid-flight has no write strobe issued.
- FETCH: imem_addr=pc. If run=1, go to DECODE next cycle. Otherwise stay in FETCH.
- DECODE: ir <= imem_data; pc <= pc+1, wrapping modulo 2^PC_W. Go to EXEC.
- EXEC: field selects and static controls are decoded from ir and stay stable through WB.
  - ADD: regdst=1, alusrc=0, memtoreg=0.
  - LOAD: regdst=0, alusrc=1, memtoreg=1.
  - STORE: alusrc=1.
  - JUMP: pc <= pc + sext(ir[5:0]), wrapping; next state FETCH, no WB.
  - All other ops: next state WB.
- WB: one-cycle strobe, then FETCH.
  - ADD: regwrite=1.
  - LOAD: memread=1 and regwrite=1.
  - STORE: memwrite=1 only.
- Latency: ADD/LOAD/STORE take 4 cycles. JUMP takes 3 cycles. Strobes are never asserted outside WB.
- Field-select outputs are combinational from ir, so the register file sees them 1 cycle before its read edge.
- run sampled low in DECODE/EXEC/WB has no effect. The current instruction completes and the sequencer halts at the next FETCH.
- JUMP with offset 0 is a no-op branch (pc = old pc+1). Offset 6'b111111 (-1) jumps to self, an infinite loop, which is legal.
- Register controls (regdst, alusrc, memtoreg) are 0 in FETCH and DECODE.

Optional Feature:
SINGLE_STEP_EN
- Defined: adds input step (1 bit). Leaving FETCH requires run=1 and a rising edge of step detected between posedges. An internal step_q register resets to 0. Exactly one instruction executes per step pulse, and a held-high step does not repeat.
- Undefined: no step port; the sequencer is free-running whenever run=1.

Test Plan:
- Reset then run=1, imem[0]=8'b00_01_10_11 (ADD) -> state sequence 0,1,2,3,0. In WB: regwrite=1, regdst=1, destination_register=3, read_register1=1, read_register2=2. Afterwards pc=1.
- LOAD imem[1]=8'b01_00_01_11 -> in WB: memread=1, regwrite=1, memtoreg=1, regdst=0, alusrc=1, imm_ext=8'hFF. memwrite stays 0.
- STORE imem[2]=8'b10_10_00_01 -> memwrite=1 for exactly 1 cycle, regwrite=0, imm_ext=8'h01. Next fetch address is 3.
- JUMP at pc=5, ir=8'b11_111101 (-3) -> pc becomes 3 after 3 cycles. No strobes asserted, WB never entered. A jump at pc=8'hFF with offset +1 wraps pc to 8'h01.
- Assert RESET in EXEC of an ADD -> next cycle state=0, pc=0, and regwrite is never asserted. run=0 mid-instruction -> the instruction completes and the sequencer holds in FETCH with imem_addr stable.
- SINGLE_STEP_EN: run=1, step held high for 20 cycles -> exactly one instruction retires. A second step pulse -> the next instruction retires.
